store_write_buffer: RTL

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: an in-order FIFO of pending stores, drained to data memory
// through an IDLE/SETUP/PULSE strobe sequence, with a load-overlap hazard check.
module store_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        storeValid,
   output logic        storeReady,
   input  logic [31:0] storeAddr,
   input  logic [31:0] storeData,
   input  logic [2:0]  storeType,
   output logic        writeRequest,
   output logic [31:0] writeAddress,
   output logic [31:0] writeData,
   output logic [2:0]  writeType,
   input  logic        loadCheck,
   input  logic [31:0] loadAddr,
   output logic        loadHazard,
   output logic        bufferEmpty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2
   } drainState_t;

   drainState_t   state;
   drainState_t   nextState;
   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [CW-1:0] count;

   logic [31:0] entryAddr [DEPTH];
   logic [31:0] entryData [DEPTH];
   logic [2:0]  entryType [DEPTH];

   logic push;
   logic pop;
   logic latchHead;
   logic latchInput;
   logic headLegal;
   logic bypassLegal;

   logic [29:0]      loadWord;
   logic [29:0]      loadNext;
   logic [PW-1:0]    slotOffset;
   logic [DEPTH-1:0] entryHit;
   logic             inFlightHit;
   logic             unusedLoadBits;

   assign storeReady  = (count < CW'(DEPTH));
   assign push        = storeValid && storeReady;
   assign headLegal   = (entryType[headPtr] <= 3'd2);
   assign bypassLegal = storeValid && (storeType <= 3'd2);
   assign bufferEmpty = (count == '0) && (state == IDLE);

   // With an empty buffer a legal incoming store is latched straight from the
   // inputs so SETUP follows acceptance directly; it is still enqueued and is
   // popped at the end of its PULSE like any other entry.
   always_comb begin
      nextState  = state;
      pop        = 1'b0;
      latchHead  = 1'b0;
      latchInput = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               if (headLegal) begin
                  latchHead = 1'b1;
                  nextState = SETUP;
               end else begin
                  pop = 1'b1;
               end
            end else if (bypassLegal) begin
               latchInput = 1'b1;
               nextState  = SETUP;
            end
         end
         SETUP: nextState = PULSE;
         PULSE: begin
            pop       = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Entry storage, pointers and occupancy; pointers wrap naturally because
   // DEPTH is a power of two.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entryAddr[i] <= '0;
            entryData[i] <= '0;
            entryType[i] <= '0;
         end
      end else begin
         if (push) begin
            entryAddr[tailPtr] <= storeAddr;
            entryData[tailPtr] <= storeData;
            entryType[tailPtr] <= storeType;
            tailPtr            <= tailPtr + PW'(1);
         end
         if (pop) begin
            headPtr <= headPtr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Drain state and the registered memory-side outputs; the write fields only
   // change on the edge leaving IDLE, so they hold through the cycle after PULSE.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         writeRequest <= 1'b0;
         writeAddress <= '0;
         writeData    <= '0;
         writeType    <= '0;
      end else begin
         state        <= nextState;
         writeRequest <= (nextState == PULSE);
         if (latchHead) begin
            writeAddress <= entryAddr[headPtr];
            writeData    <= entryData[headPtr];
            writeType    <= entryType[headPtr];
         end else if (latchInput) begin
            writeAddress <= storeAddr;
            writeData    <= storeData;
            writeType    <= storeType;
         end
      end
   end

   // A load overlaps a store when the store's word is the load's word or the
   // next one up (misaligned loads can spill into it).
   always_comb begin
      loadWord   = loadAddr[31:2];
      loadNext   = loadWord + 30'd1;
      slotOffset = '0;
      entryHit   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slotOffset  = PW'(i) - headPtr;
         entryHit[i] = (CW'(slotOffset) < count) &&
                       ((entryAddr[i][31:2] == loadWord) || (entryAddr[i][31:2] == loadNext));
      end
   end

   assign inFlightHit    = (state != IDLE) &&
                           ((writeAddress[31:2] == loadWord) || (writeAddress[31:2] == loadNext));
   assign loadHazard     = loadCheck && ((|entryHit) || inFlightHit);
   assign unusedLoadBits = ^loadAddr[1:0];

endmodule
